// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter and its load FIFO.
package wb_arbiter_pkg;
  localparam int REGFILE_SIZE  = 32;
  localparam int WB_IDX_W      = $clog2(REGFILE_SIZE);
  localparam int WB_DATA_W     = 32;
  localparam int WB_FIFO_DEPTH = 4;

  localparam logic [WB_IDX_W-1:0] WB_IDX_ZERO = {WB_IDX_W{1'b0}};

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_ALU    = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } wb_sel_e;
endpackage

// File: rtl/wb_fifo.sv
// Load-return FIFO: storage, wrapping pointers and occupancy; no selection logic.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = WB_FIFO_DEPTH,
  parameter int IDX_W  = WB_IDX_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [IDX_W-1:0]       push_dest,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [IDX_W-1:0]       head_dest,
  output logic [DATA_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [IDX_W-1:0]  dest_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    cnt_r;
  logic              push_s;
  logic              pop_s;

  assign full      = (cnt_r == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt_r == {(PTR_W+1){1'b0}});
  assign push_s    = push && !full;
  assign pop_s     = pop && !empty;
  assign cnt       = cnt_r;
  assign head_dest = dest_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];

  // Entry storage; contents are only meaningful below the occupancy count
  always_ff @(posedge CLK) begin
    if (push_s) begin
      dest_mem_r[wr_ptr_r] <= push_dest;
      data_mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (PTR_W+1)'(1);
        2'b01:   cnt_r <= cnt_r - (PTR_W+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU priority, buffered load returns, pending scoreboard.
// Optional macro WB_LOAD_BYPASS_EN lets a load skip an empty FIFO for 1-cycle latency.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = WB_FIFO_DEPTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    alu_valid,
  input  logic [WB_IDX_W-1:0]     alu_dest,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [WB_IDX_W-1:0]     ld_dest,
  input  logic [DATA_W-1:0]       ld_data,
  input  logic                    iss_valid,
  input  logic [WB_IDX_W-1:0]     iss_dest,
  output logic                    we,
  output logic [WB_IDX_W-1:0]     waddr,
  output logic [DATA_W-1:0]       wdata,
  output logic [REGFILE_SIZE-1:0] pending,
  output logic [$clog2(DEPTH):0]  fifo_cnt
);
  wb_sel_e                 sel_s;
  logic                    alu_wr_s;
  logic                    ld_take_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [WB_IDX_W-1:0]     head_dest_s;
  logic [DATA_W-1:0]       head_data_s;
  logic [REGFILE_SIZE-1:0] pend_nxt_s;
  logic                    we_r;
  logic [WB_IDX_W-1:0]     waddr_r;
  logic [DATA_W-1:0]       wdata_r;
  logic [REGFILE_SIZE-1:0] pending_r;

  // Ready comes from the current count only, so a full FIFO popping this cycle still refuses
  assign ld_ready  = !RST && !fifo_full_s;
  assign alu_wr_s  = alu_valid && (alu_dest != WB_IDX_ZERO);
  assign ld_take_s = ld_valid && ld_ready && (ld_dest != WB_IDX_ZERO);
  assign push_s    = ld_take_s && (sel_s != SEL_BYPASS);
  assign pop_s     = (sel_s == SEL_FIFO);

  wb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(WB_IDX_W)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_s),
    .push_dest (ld_dest),
    .push_data (ld_data),
    .pop       (pop_s),
    .head_dest (head_dest_s),
    .head_data (head_data_s),
    .cnt       (fifo_cnt),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Write-source selection: ALU first, then queued loads, then (optionally) the incoming load
  always_comb begin
    sel_s = SEL_NONE;
    if (alu_wr_s) begin
      sel_s = SEL_ALU;
    end else if (!fifo_empty_s) begin
      sel_s = SEL_FIFO;
`ifdef WB_LOAD_BYPASS_EN
    end else if (ld_take_s) begin
      sel_s = SEL_BYPASS;
`endif
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Registered write port; address and data hold when nothing is written
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_r    <= 1'b0;
      waddr_r <= WB_IDX_ZERO;
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      case (sel_s)
        SEL_ALU: begin
          we_r    <= 1'b1;
          waddr_r <= alu_dest;
          wdata_r <= alu_data;
        end
        SEL_FIFO: begin
          we_r    <= 1'b1;
          waddr_r <= head_dest_s;
          wdata_r <= head_data_s;
        end
        SEL_BYPASS: begin
          we_r    <= 1'b1;
          waddr_r <= ld_dest;
          wdata_r <= ld_data;
        end
        default: we_r <= 1'b0;
      endcase
    end
  end

  // Scoreboard next state: a commit clears, a new issue sets, and set wins on the same index
  always_comb begin
    pend_nxt_s = pending_r;
    if (we_r) begin
      pend_nxt_s[waddr_r] = 1'b0;
    end else begin
      pend_nxt_s = pending_r;
    end
    if (iss_valid && (iss_dest != WB_IDX_ZERO)) begin
      pend_nxt_s[iss_dest] = 1'b1;
    end else begin
      pend_nxt_s[0] = 1'b0;
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_r <= {REGFILE_SIZE{1'b0}};
    end else begin
      pending_r <= pend_nxt_s;
    end
  end

  assign we      = we_r;
  assign waddr   = waddr_r;
  assign wdata   = wdata_r;
  assign pending = pending_r;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
`ifdef WB_LOAD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_dest = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_dest = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_dest = 5'd0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pending;
  logic [2:0]  fifo_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [36:0] q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_pend = 32'd0;
  logic        m_acc = 1'b0;

  wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .we(we), .waddr(waddr), .wdata(wdata), .pending(pending), .fifo_cnt(fifo_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the arbiter's rules to the inputs seen at this clock edge.
  task automatic model_step();
    logic        take;
    logic [31:0] np;
    logic [36:0] e;
    if (RST) begin
      q.delete();
      m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_pend = 32'd0; m_acc = 1'b0;
    end else begin
      m_acc = ld_valid && (q.size() < DEPTH);
      take  = m_acc && (ld_dest != 5'd0);
      np = m_pend;
      if (m_we) np[m_waddr] = 1'b0;
      if (iss_valid && iss_dest != 5'd0) np[iss_dest] = 1'b1;
      if (alu_valid && alu_dest != 5'd0) begin
        m_we = 1'b1; m_waddr = alu_dest; m_wdata = alu_data;
        if (take) q.push_back({ld_dest, ld_data});
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_waddr = e[36:32]; m_wdata = e[31:0];
        if (take) q.push_back({ld_dest, ld_data});
      end else if (BYPASS && take) begin
        m_we = 1'b1; m_waddr = ld_dest; m_wdata = ld_data;
      end else begin
        m_we = 1'b0;
        if (take) q.push_back({ld_dest, ld_data});
      end
      m_pend = np;
    end
  endtask

  task automatic compare_all();
    chk("we", 64'(we), 64'(m_we));
    chk("waddr", 64'(waddr), 64'(m_waddr));
    chk("wdata", 64'(wdata), 64'(m_wdata));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
    chk("ld_ready", 64'(ld_ready), 64'(!RST && (q.size() < DEPTH)));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    int ld_n;
    int stale;
    logic [4:0] order[$];

    // reset, then idle
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_ready", 64'(ld_ready), 64'd1);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    tick();

    // ALU write and ALU to r0
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h1234;
    tick();
    chk("alu_we", 64'(we), 64'd1);
    chk("alu_waddr", 64'(waddr), 64'd3);
    chk("alu_wdata", 64'(wdata), 64'h1234);
    alu_dest = 5'd0; alu_data = 32'h5555;
    tick();
    chk("alu0_we", 64'(we), 64'd0);
    chk("alu0_hold", 64'(wdata), 64'h1234);
    idle();

    // issue r8, then load to r8
    iss_valid = 1'b1; iss_dest = 5'd8;
    tick();
    chk("iss8_set", 64'(pending[8]), 64'd1);
    iss_valid = 1'b0;
    ld_valid = 1'b1; ld_dest = 5'd8; ld_data = 32'hDEAD;
    tick();
    ld_valid = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    chk("ld8_we_t1", 64'(we), 64'd1);
    chk("ld8_data_t1", 64'(wdata), 64'hDEAD);
    chk("ld8_pend_t1", 64'(pending[8]), 64'd1);
    tick();
    chk("ld8_clear", 64'(pending[8]), 64'd0);
`else
    chk("ld8_we_t1", 64'(we), 64'd0);
    chk("ld8_cnt_t1", 64'(fifo_cnt), 64'd1);
    tick();
    chk("ld8_we_t2", 64'(we), 64'd1);
    chk("ld8_addr_t2", 64'(waddr), 64'd8);
    chk("ld8_data_t2", 64'(wdata), 64'hDEAD);
    chk("ld8_pend_t2", 64'(pending[8]), 64'd1);
    tick();
    chk("ld8_clear", 64'(pending[8]), 64'd0);
`endif

    // ALU busy for 6 cycles while 5 loads are offered
    ld_n = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_dest = 5'(10 + i); alu_data = 32'hA000 + 32'(i);
      ld_valid = (ld_n < 5); ld_dest = 5'(20 + ld_n); ld_data = 32'hB000 + 32'(ld_n);
      tick();
      if (m_acc) ld_n++;
    end
    chk("full_cnt", 64'(fifo_cnt), 64'd4);
    chk("full_ready", 64'(ld_ready), 64'd0);
    chk("full_accepted", 64'(ld_n), 64'd4);
    for (int i = 0; i < 12; i++) begin
      alu_valid = (i % 2 == 0); alu_dest = 5'd0; alu_data = 32'hFFFF;
      ld_valid = (ld_n < 5); ld_dest = 5'(20 + ld_n); ld_data = 32'hB000 + 32'(ld_n);
      tick();
      if (m_acc) ld_n++;
      if (we) order.push_back(waddr);
      if (i == 0) begin
        chk("drain0_addr", 64'(waddr), 64'd20);
        chk("drain0_data", 64'(wdata), 64'hB000);
        chk("drain0_cnt", 64'(fifo_cnt), 64'd3);
      end
    end
    idle();
    chk("drain_count", 64'(order.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk("drain_order", 64'(order[i]), 64'(20 + i));
    end
    chk("drain_empty", 64'(fifo_cnt), 64'd0);

    // set and clear of r9 on the same edge
    iss_valid = 1'b1; iss_dest = 5'd9;
    tick();
    iss_valid = 1'b0; alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h99;
    tick();
    chk("r9_commit", 64'(waddr), 64'd9);
    alu_valid = 1'b0; iss_valid = 1'b1; iss_dest = 5'd9;
    tick();
    chk("r9_setwins", 64'(pending[9]), 64'd1);
    iss_valid = 1'b0;
    tick();
    chk("r9_kept", 64'(pending[9]), 64'd1);
    alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h98;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("r9_cleared", 64'(pending[9]), 64'd0);

    // reset with 3 queued loads
    iss_valid = 1'b1; iss_dest = 5'd12;
    tick();
    iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'hC0 + 32'(i);
      ld_valid = 1'b1; ld_dest = 5'(25 + i); ld_data = 32'hD0 + 32'(i);
      tick();
    end
    chk("pre_rst_cnt", 64'(fifo_cnt), 64'd3);
    idle();
    RST = 1'b1;
    tick();
    chk("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("mid_rst_pending", 64'(pending), 64'd0);
    RST = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (we && waddr >= 5'd25 && waddr <= 5'd27) stale++;
    end
    chk("no_stale_writes", 64'(stale), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
